rotary_encoder_array: RTL

ROTARY_ENCODER_ARRAY -- requirements
Module: rotary_encoder_array

---
 rtl/rotary_pkg.sv | 50 +++++
 rtl/debounce_filter.sv | 51 +++++
 rtl/rotary_encoder_array.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary encoder array: quadrature state encoding,
// detent accumulator constants and debounce counter sizing.
package rotary_pkg;

    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_01 = 2'b01;
    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_10 = 2'b10;

    localparam int ACC_DETENT = 3;
    localparam int ACC_WIDTH  = 3;

    typedef enum logic [1:0] {
        StepNone,
        StepFwd,
        StepRev,
        StepIllegal
    } step_e;

    // Counter only needs to reach DEBOUNCE_CYCLES-1 before the filter flips.
    function automatic int cnt_width(input int cycles);
        cnt_width = (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

    // Position of a quadrature state along the clockwise cycle 11->01->00->10.
    function automatic logic [1:0] quad_idx(input logic [1:0] ab);
        logic [1:0] idx;
        case (ab)
            QS_11:   idx = 2'd0;
            QS_01:   idx = 2'd1;
            QS_00:   idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic step_e quad_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] delta;
        step_e      step;
        delta = quad_idx(cur) - quad_idx(prev);
        case (delta)
            2'd0:    step = StepNone;
            2'd1:    step = StepFwd;
            2'd3:    step = StepRev;
            default: step = StepIllegal;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer followed by a consecutive-cycle debounce filter for one
// asynchronous pin.
module debounce_filter
    import rotary_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter logic        RST_VAL         = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_dout
);

    localparam int CNT_W = cnt_width(int'(DEBOUNCE_CYCLES));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_filt;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= RST_VAL;
            r_sync2 <= RST_VAL;
        end else begin
            r_sync1 <= i_din;
            r_sync2 <= r_sync1;
        end
    end

    // Any cycle that agrees with the filtered value restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt <= RST_VAL;
            r_cnt  <= '0;
        end else if (r_sync2 == r_filt) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_filt <= r_sync2;
            r_cnt  <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign o_dout = r_filt;

endmodule

// File: rtl/rotary_encoder_array.sv
// Array of independent quadrature rotary encoders with push switches: debounced
// inputs, detent decoding, signed position counters and sticky error flags.
module rotary_encoder_array
    import rotary_pkg::*;
#(
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned POS_WIDTH       = 8,
    parameter int unsigned WRAP            = 0,
    parameter int unsigned BTN_ACTIVE_LOW  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             in_a,
    input  logic [NUM_CH-1:0]             in_b,
    input  logic [NUM_CH-1:0]             switch,
    input  logic [NUM_CH-1:0]             clr,
    output logic [NUM_CH-1:0]             up,
    output logic [NUM_CH-1:0]             down,
    output logic [NUM_CH-1:0]             button,
    output logic [NUM_CH-1:0]             press,
    output logic [NUM_CH*POS_WIDTH-1:0]   pos,
    output logic [NUM_CH-1:0]             err
);

    localparam logic SW_RELEASED = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam logic signed [ACC_WIDTH-1:0] ACC_HI  = ACC_WIDTH'(ACC_DETENT);
    localparam logic signed [ACC_WIDTH-1:0] ACC_LO  = -ACC_HI;
    localparam logic signed [ACC_WIDTH-1:0] ACC_ONE = ACC_WIDTH'(1);

    localparam logic signed [POS_WIDTH-1:0] POS_MAX = {1'b0, {(POS_WIDTH-1){1'b1}}};
    localparam logic signed [POS_WIDTH-1:0] POS_MIN = {1'b1, {(POS_WIDTH-1){1'b0}}};
    localparam logic signed [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_fa;
        logic w_fb;
        logic w_fs;

        debounce_filter #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RST_VAL         (1'b1)
        ) u_db_a (
            .clk    (clk),
            .rst    (rst),
            .i_din  (in_a[g]),
            .o_dout (w_fa)
        );

        debounce_filter #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RST_VAL         (1'b1)
        ) u_db_b (
            .clk    (clk),
            .rst    (rst),
            .i_din  (in_b[g]),
            .o_dout (w_fb)
        );

        debounce_filter #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RST_VAL         (SW_RELEASED)
        ) u_db_sw (
            .clk    (clk),
            .rst    (rst),
            .i_din  (switch[g]),
            .o_dout (w_fs)
        );

        logic [1:0]                   r_state;
        logic signed [ACC_WIDTH-1:0]  r_acc;
        logic signed [POS_WIDTH-1:0]  r_pos;
        logic                         r_up;
        logic                         r_down;
        logic                         r_err;
        logic                         r_btn_prev;
        logic                         r_press;

        logic [1:0] w_cur;
        step_e      w_step;
        logic       w_enter_11;
        logic       w_up;
        logic       w_down;
        logic       w_btn;

        assign w_cur      = {w_fa, w_fb};
        assign w_step     = quad_step(r_state, w_cur);
        assign w_enter_11 = (w_cur == QS_11) && (r_state != QS_11);
        // A detent completes only when the full quarter-cycle history precedes the entry.
        assign w_up       = w_enter_11 && (w_step == StepFwd) && (r_acc == ACC_HI);
        assign w_down     = w_enter_11 && (w_step == StepRev) && (r_acc == ACC_LO);
        assign w_btn      = (BTN_ACTIVE_LOW != 0) ? ~w_fs : w_fs;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= QS_11;
                r_acc   <= '0;
                r_up    <= 1'b0;
                r_down  <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                r_state <= w_cur;
                r_up    <= w_up;
                r_down  <= w_down;
                if (w_step == StepIllegal) begin
                    r_err <= 1'b1;
                    r_acc <= '0;
                end else if (w_enter_11) begin
                    r_acc <= '0;
                end else if (w_step == StepFwd) begin
                    r_acc <= r_acc + ACC_ONE;
                end else if (w_step == StepRev) begin
                    r_acc <= r_acc - ACC_ONE;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_pos <= '0;
            end else if (clr[g]) begin
                r_pos <= '0;
            end else if (w_up) begin
                if ((WRAP != 0) || (r_pos != POS_MAX)) begin
                    r_pos <= r_pos + POS_ONE;
                end
            end else if (w_down) begin
                if ((WRAP != 0) || (r_pos != POS_MIN)) begin
                    r_pos <= r_pos - POS_ONE;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_btn_prev <= 1'b0;
                r_press    <= 1'b0;
            end else begin
                r_btn_prev <= w_btn;
                r_press    <= w_btn & ~r_btn_prev;
            end
        end

        assign up[g]                          = r_up;
        assign down[g]                        = r_down;
        assign err[g]                         = r_err;
        assign button[g]                      = w_btn;
        assign press[g]                       = r_press;
        assign pos[g*POS_WIDTH +: POS_WIDTH]  = r_pos;
    end

endmodule
